dmem_access_arbiter: RTL

//  Arbitrates the single-port data memory between the pipeline MEM stage (CPU) and
//  an external loader/debug port (EXT). CPU has fixed priority; a starvation counter

---
 rtl/dmem_access_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dmem_access_arbiter.sv
`timescale 1ns/1ps
// dmem_access_arbiter
// Shares the single-port data memory between the CPU MEM stage and an
// external loader/debug port. The CPU has fixed priority. A starvation counter
// forces an EXT grant after STARVE_LIMIT contended cycles. EXT is served as a
// word burst with an auto-incrementing address.
// Optional build macro: DMEM_ARB_MISALIGN_EN adds misaligned-CPU-access
// suppression and the cpu_misalign output.
module dmem_access_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned LEN_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [2:0]       cpu_func3,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             ext_req,
  input  logic             ext_we,
  input  logic [31:0]      ext_addr,
  input  logic [LEN_W-1:0] ext_len,
  output logic             ext_gnt,
  input  logic             ext_wvalid,
  input  logic [31:0]      ext_wdata,
  output logic             ext_wready,
  output logic             ext_rvalid,
  output logic [31:0]      ext_rdata,
  output logic             ext_busy,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [2:0]       mem_func3,
  output logic             mem_we,
  input  logic [31:0]      mem_rdata
`ifdef DMEM_ARB_MISALIGN_EN
  ,
  output logic             cpu_misalign
`endif
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      base_q;
  logic             we_q;

  logic grant;
  logic beat_adv;
  logic last_beat;
  logic misal;

  // Grant is evaluated in IDLE only; a starved EXT wins even against cpu_req.
  assign grant     = (state == IDLE) && ext_req && (!cpu_req || (starve_cnt == LIMIT));
  assign ext_gnt   = grant && !reset;
  assign beat_adv  = !we_q || ext_wvalid;
  assign last_beat = (beat_cnt == len_q);
  assign cpu_rdata = mem_rdata;

`ifdef DMEM_ARB_MISALIGN_EN
  assign misal = cpu_req &&
                 (((cpu_func3[1:0] == 2'b01) && cpu_addr[0]) ||
                  ((cpu_func3[1:0] == 2'b10) && (cpu_addr[1:0] != 2'b00)));
  assign cpu_misalign = (state == IDLE) && misal && !reset;
`else
  assign misal = 1'b0;
`endif

  // Memory-side mux: CPU passes through in IDLE, burst engine owns it in BURST.
  always_comb begin
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_func3  = cpu_func3;
    mem_we     = cpu_req && cpu_we && !misal;
    cpu_stall  = 1'b0;
    ext_wready = 1'b0;
    ext_busy   = 1'b0;
    if (state == BURST) begin
      mem_addr   = base_q + (32'(beat_cnt) << 2);
      mem_wdata  = ext_wdata;
      mem_func3  = 3'b010;
      mem_we     = we_q && ext_wvalid;
      cpu_stall  = cpu_req;
      ext_wready = we_q;
      ext_busy   = 1'b1;
    end
  end

  // Arbiter FSM, starvation counter, burst beat tracking and read-beat register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      beat_cnt   <= '0;
      len_q      <= '0;
      base_q     <= '0;
      we_q       <= 1'b0;
      ext_rvalid <= 1'b0;
      ext_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ext_rvalid <= 1'b0;
          if (grant) begin
            base_q     <= ext_addr & 32'hFFFF_FFFC;
            len_q      <= ext_len;
            we_q       <= ext_we;
            beat_cnt   <= '0;
            starve_cnt <= '0;
            state      <= BURST;
          end else if (!ext_req) begin
            starve_cnt <= '0;
          end else if (cpu_req && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        BURST: begin
          ext_rvalid <= !we_q;
          if (!we_q) begin
            ext_rdata <= mem_rdata;
          end
          if (beat_adv) begin
            if (last_beat) begin
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
